// File: rtl/mm4_argmax_reader_if.sv
// mm4_argmax_reader_if
// Bundles the start/status/result signals and the score-memory read port of
// mm4_argmax_reader into one connection.
//   start        : scan request from the controller
//   read_addr    : address to the score memory read port (16 bits)
//   read_data    : combinational memory read data (DATA_WIDTH, signed)
//   busy, done   : scan in progress / one-cycle results-valid pulse
//   max_*        : index and value of the largest score
//   second_*     : runner-up index and value (zero unless runner-up tracking is built)
// Modports: slave = the argmax reader, master = controller plus memory side.
interface mm4_argmax_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [15:0]           read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  busy;
  logic                  done;
  logic [3:0]            max_index;
  logic [DATA_WIDTH-1:0] max_value;
  logic [3:0]            second_index;
  logic [DATA_WIDTH-1:0] second_value;

  modport slave (
    input  start, read_data,
    output read_addr, busy, done, max_index, max_value, second_index, second_value
  );

  modport master (
    output start, read_data,
    input  read_addr, busy, done, max_index, max_value, second_index, second_value
  );
endinterface

// File: rtl/mm4_argmax_reader.sv
// mm4_argmax_reader
// Scans DEPTH signed scores from the layer-4 output memory, one word per
// cycle through its combinational read port, and reports the index/value of
// the largest score (lowest index wins ties), then pulses done.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : mm4_argmax_reader_if.slave (start, read_addr/read_data,
//            busy, done, max_index/max_value, second_index/second_value)
// Optional feature: define MM4_ARGMAX_SECOND_EN to build runner-up tracking;
// without it second_index/second_value are constant zero.
module mm4_argmax_reader #(
  parameter int DEPTH      = 10,
  parameter int BASE_ADDR  = 0,
  parameter int DATA_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  mm4_argmax_reader_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]  LAST_IDX = 4'(DEPTH - 1);
  localparam logic [15:0] BASE16   = 16'(BASE_ADDR);

  state_t                       state_r;
  logic [3:0]                   idx_r;
  logic                         busy_r;
  logic                         done_r;
  logic [3:0]                   max_index_r;
  logic signed [DATA_WIDTH-1:0] max_value_r;
  logic signed [DATA_WIDTH-1:0] read_data_s;
  logic                         gt_max_s;
  logic [15:0]                  read_addr_s;

  assign read_data_s = $signed(bus.read_data);
  assign gt_max_s    = (read_data_s > max_value_r);

  // Memory address decodes only from registered state and counter.
  always_comb begin
    read_addr_s = BASE16;
    if (state_r == SCAN) begin
      read_addr_s = BASE16 + {12'd0, idx_r};
    end else begin
      read_addr_s = BASE16;
    end
  end

  assign bus.read_addr = read_addr_s;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.max_index = max_index_r;
  assign bus.max_value = max_value_r;

  // Control FSM with registered status outputs and the max tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= 4'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      max_index_r <= 4'd0;
      max_value_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            state_r <= SCAN;
            idx_r   <= 4'd0;
            busy_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        SCAN: begin
          // First sample seeds the max; later ones replace it only when
          // strictly larger, so the lowest index keeps a tie.
          if (idx_r == 4'd0) begin
            max_value_r <= read_data_s;
            max_index_r <= 4'd0;
          end else if (gt_max_s) begin
            max_value_r <= read_data_s;
            max_index_r <= idx_r;
          end
          if (idx_r == LAST_IDX) begin
            state_r <= DONE;
            idx_r   <= 4'd0;
            done_r  <= 1'b1;
          end else begin
            idx_r   <= idx_r + 4'd1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          idx_r   <= 4'd0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MM4_ARGMAX_SECOND_EN
  logic [3:0]                   second_index_r;
  logic signed [DATA_WIDTH-1:0] second_value_r;
  logic                         second_valid_r;

  // Runner-up tracker: a demoted max becomes the runner-up; otherwise a new
  // word takes the slot when it is empty or strictly beats the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_index_r <= 4'd0;
      second_value_r <= '0;
      second_valid_r <= 1'b0;
    end else if (state_r == SCAN) begin
      if (idx_r == 4'd0) begin
        second_index_r <= 4'd0;
        second_value_r <= '0;
        second_valid_r <= 1'b0;
      end else if (gt_max_s) begin
        second_index_r <= max_index_r;
        second_value_r <= max_value_r;
        second_valid_r <= 1'b1;
      end else if (!second_valid_r || (read_data_s > second_value_r)) begin
        second_index_r <= idx_r;
        second_value_r <= read_data_s;
        second_valid_r <= 1'b1;
      end
    end
  end

  assign bus.second_index = second_index_r;
  assign bus.second_value = second_value_r;
`else
  assign bus.second_index = 4'd0;
  assign bus.second_value = '0;
`endif

endmodule

// File: tb/tb_mm4_argmax_reader.sv
// tb_mm4_argmax_reader
// Self-checking bench for mm4_argmax_reader (DEPTH=10, BASE_ADDR=0).
// A small array models the score memory; expected results come from
// hand-derived vector tables and from a sort-based reference model.
module tb_mm4_argmax_reader;

  localparam int DEPTH = 10;
  localparam int DW    = 32;

  typedef logic [DEPTH-1:0][DW-1:0] scores_t;

  typedef struct packed {
    scores_t     sc;
    logic [3:0]  exp_idx;
    logic [31:0] exp_val;
    logic [3:0]  exp_sidx;
    logic [31:0] exp_sval;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem [0:15];
  int          n_checks;
  int          n_fail;

  mm4_argmax_reader_if #(.DATA_WIDTH(DW)) bus ();

  mm4_argmax_reader #(.DEPTH(DEPTH), .BASE_ADDR(0), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.read_data = (bus.read_addr < 16'd16) ? mem[bus.read_addr[3:0]] : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: stable sort of indices by value (descending), take top two.
  task automatic model(input scores_t sc, output logic [3:0] mi, output logic [31:0] mv,
                       output logic [3:0] si, output logic [31:0] sv);
    int ord [DEPTH];
    int t;
    for (int k = 0; k < DEPTH; k++) ord[k] = k;
    for (int p = 0; p < DEPTH; p++) begin
      for (int j = 0; j < DEPTH - 1; j++) begin
        if ($signed(sc[ord[j+1]]) > $signed(sc[ord[j]])) begin
          t = ord[j]; ord[j] = ord[j+1]; ord[j+1] = t;
        end
      end
    end
    mi = 4'(ord[0]);
    mv = sc[ord[0]];
`ifdef MM4_ARGMAX_SECOND_EN
    si = 4'(ord[1]);
    sv = sc[ord[1]];
`else
    si = 4'd0;
    sv = 32'd0;
`endif
  endtask

  task automatic load(input scores_t sc);
    for (int k = 0; k < 16; k++) mem[k] = (k < DEPTH) ? sc[k] : 32'h0BAD_0000;
  endtask

  // Pulse start for one cycle and count cycles until done (cycle 0 = start sampled).
  task automatic run_scan(input scores_t sc, output int lat);
    load(sc);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_results(input string tag, input logic [3:0] mi, input logic [31:0] mv,
                             input logic [3:0] si, input logic [31:0] sv);
    chk({tag, " max_index"},    {28'd0, bus.max_index},    {28'd0, mi});
    chk({tag, " max_value"},    bus.max_value,             mv);
    chk({tag, " second_index"}, {28'd0, bus.second_index}, {28'd0, si});
    chk({tag, " second_value"}, bus.second_value,          sv);
  endtask

  function automatic scores_t mk(input int a [DEPTH]);
    scores_t s;
    for (int k = 0; k < DEPTH; k++) s[k] = 32'(a[k]);
    return s;
  endfunction

  initial begin
    vec_t        vecs [5];
    int          a [DEPTH];
    int          lat;
    int          c;
    int          done_cnt;
    int          done_at [$];
    scores_t     sc;
    logic [3:0]  mi, si;
    logic [31:0] mv, sv;
    logic [3:0]  exp_si;
    logic [31:0] exp_sv;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = 32'd0;

    // Hand-derived vectors: {scores, max idx, max val, second idx, second val}.
    a = '{5, -3, 12, 7, 12, 0, -100, 11, 1, 2};
    vecs[0] = '{mk(a), 4'd2, 32'd12, 4'd4, 32'd12};
    for (int k = 0; k < DEPTH; k++) a[k] = 32'sh8000_0000;
    vecs[1] = '{mk(a), 4'd0, 32'h8000_0000, 4'd1, 32'h8000_0000};
    for (int k = 0; k < DEPTH; k++) a[k] = -(k + 1);
    vecs[2] = '{mk(a), 4'd0, 32'hFFFF_FFFF, 4'd1, 32'hFFFF_FFFE};
    a = '{-5, 3, 3, -7, 0, 1, 2, 3, -1, 32'sh7FFF_FFFF};
    vecs[3] = '{mk(a), 4'd9, 32'h7FFF_FFFF, 4'd1, 32'd3};
    a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{mk(a), 4'd0, 32'd0, 4'd1, 32'd0};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset busy",      {31'd0, bus.busy}, 32'd0);
    chk("reset done",      {31'd0, bus.done}, 32'd0);
    chk("reset read_addr", {16'd0, bus.read_addr}, 32'd0);
    chk_results("reset", 4'd0, 32'd0, 4'd0, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors.
    for (int v = 0; v < 5; v++) begin
`ifdef MM4_ARGMAX_SECOND_EN
      exp_si = vecs[v].exp_sidx;
      exp_sv = vecs[v].exp_sval;
`else
      exp_si = 4'd0;
      exp_sv = 32'd0;
`endif
      run_scan(vecs[v].sc, lat);
      chk($sformatf("vec%0d latency", v), 32'(lat), 32'd11);
      chk($sformatf("vec%0d busy at done", v), {31'd0, bus.busy}, 32'd1);
      chk_results($sformatf("vec%0d", v), vecs[v].exp_idx, vecs[v].exp_val, exp_si, exp_sv);
      @(negedge clk);
      chk($sformatf("vec%0d done width", v), {31'd0, bus.done}, 32'd0);
      chk($sformatf("vec%0d busy after", v), {31'd0, bus.busy}, 32'd0);
      chk_results($sformatf("vec%0d hold", v), vecs[v].exp_idx, vecs[v].exp_val, exp_si, exp_sv);
    end

    // Randomized vectors against the reference model; small ranges force ties.
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if ((r % 2) == 0) sc[k] = 32'($signed($urandom_range(0, 6)) - 3);
        else              sc[k] = $urandom;
      end
      model(sc, mi, mv, si, sv);
      run_scan(sc, lat);
      chk($sformatf("rand%0d latency", r), 32'(lat), 32'd11);
      chk_results($sformatf("rand%0d", r), mi, mv, si, sv);
    end

    // read_addr trace with a start pulse mid-scan that must be ignored.
    load(vecs[0].sc);
    @(negedge clk);
    chk("trace idle addr", {16'd0, bus.read_addr}, 32'd0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (c = 1; c <= 11; c++) begin
      if (c <= 10) chk($sformatf("trace addr c%0d", c), {16'd0, bus.read_addr}, 32'(c - 1));
      else         chk("trace addr done", {16'd0, bus.read_addr}, 32'd0);
      chk($sformatf("trace busy c%0d", c), {31'd0, bus.busy}, 32'd1);
      chk($sformatf("trace done c%0d", c), {31'd0, bus.done}, (c == 11) ? 32'd1 : 32'd0);
      bus.start = (c == 5) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("trace addr after", {16'd0, bus.read_addr}, 32'd0);
    chk("trace busy after", {31'd0, bus.busy}, 32'd0);
`ifdef MM4_ARGMAX_SECOND_EN
    chk_results("trace", 4'd2, 32'd12, 4'd4, 32'd12);
`else
    chk_results("trace", 4'd2, 32'd12, 4'd0, 32'd0);
`endif
    repeat (3) @(negedge clk);
    chk("trace no restart", {31'd0, bus.busy}, 32'd0);

    // Reset at SCAN i=5: everything clears at once and no done follows.
    load(vecs[2].sc);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("prereset addr i5", {16'd0, bus.read_addr}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("midrst busy",      {31'd0, bus.busy}, 32'd0);
    chk("midrst done",      {31'd0, bus.done}, 32'd0);
    chk("midrst read_addr", {16'd0, bus.read_addr}, 32'd0);
    chk_results("midrst", 4'd0, 32'd0, 4'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
    end
    chk("post reset idle", 32'(done_cnt), 32'd0);
    model(vecs[3].sc, mi, mv, si, sv);
    run_scan(vecs[3].sc, lat);
    chk("post reset latency", 32'(lat), 32'd11);
    chk_results("post reset", mi, mv, si, sv);
    @(negedge clk);

    // start held high for 30 cycles: done at cycles 11 and 23, one cycle each.
    load(vecs[0].sc);
    bus.start = 1'b1;
    for (c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_at.push_back(c);
    end
    bus.start = 1'b0;
    chk("b2b done count", 32'(done_at.size()), 32'd2);
    chk("b2b first done",  (done_at.size() > 0) ? 32'(done_at[0]) : 32'hFFFF_FFFF, 32'd11);
    chk("b2b second done", (done_at.size() > 1) ? 32'(done_at[1]) : 32'hFFFF_FFFF, 32'd23);
    c = 0;
    while (bus.busy === 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("b2b drain", {31'd0, bus.busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
